// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl - raster sequencer for the 640x480 display path.
//
// Turns the 25 MHz pixel_rate square wave into one-cycle pixel strobes in
// the CLK_NX domain and steps the horizontal/vertical counters. It also
// decodes sync, the active-video window and pixel coordinates. A run/stop
// FSM (IDLE/RUN/DRAIN) starts raster output when asked and only ever stops
// at a frame boundary.
//
// Ports:
//   CLK_NX      in   100 MHz system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   pixel_rate  in   25 MHz square wave, synchronous to CLK_NX
//   run         in   level request to produce raster
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  high inside the visible window
//   pixel_x     out  horizontal counter (10 bits)
//   pixel_y     out  vertical counter (10 bits)
//   pixel_tick  out  one-cycle strobe per pixel
//   busy        out  high while in RUN or DRAIN
//   frame_start out  one-cycle pulse on entering (0,0)
//
// Optional feature: define VGA_FRAME_TICK_EN to build the frame_start pulse
// logic. When it is undefined, frame_start is tied low.
//
// Handshake: there is no valid/ready pair. run is a level request. It is
// sampled every cycle, but starting only happens on a pixel tick.
//
// Timing parameters must sum to at most 1024 per axis. The counters are
// 10 bits wide and that limit is not checked here.
module vga_sync_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       CLK_NX,
  input  logic       reset_n,
  input  logic       pixel_rate,
  input  logic       run,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_tick,
  output logic       busy,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       pr_d;
  logic       tick;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nx, v_nx;
  logic       at_end;
  logic       adv;

  // Rising-edge detect of the pixel clock: high for exactly one CLK_NX cycle.
  assign tick   = pixel_rate & ~pr_d;
  assign at_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_comb begin
    state_nx = state;
    adv      = 1'b0;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    case (state)
      S_IDLE: begin
        // Position (0,0) is shown on the starting tick itself, so the
        // counters do not advance on this tick.
        if (tick && run) state_nx = S_RUN;
      end
      S_RUN: begin
        adv = tick;
        // A stop request that lands on the final-pixel tick ends the frame
        // now. It does not drain a whole extra frame.
        if (!run) state_nx = (tick && at_end) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        adv = tick;
        // Frame completion has priority over a new run request. The request
        // is picked up again from IDLE on a later tick.
        if (tick && at_end) state_nx = S_IDLE;
        else if (run)       state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase

    if (adv) begin
      if (h_cnt == H_LAST) begin
        h_nx = '0;
        v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nx = h_cnt + 10'd1;
      end
    end

    if (state_nx == S_IDLE) begin
      h_nx = '0;
      v_nx = '0;
    end
  end

  // Outputs are decoded from the next-state counters, so they change on the
  // same edge as the counters.
  always_ff @(posedge CLK_NX or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pr_d       <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pixel_tick <= 1'b0;
      busy       <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
    end else begin
      state      <= state_nx;
      pr_d       <= pixel_rate;
      h_cnt      <= h_nx;
      v_cnt      <= v_nx;
      pixel_tick <= tick;
      busy       <= (state_nx != S_IDLE);
      if (state_nx == S_IDLE) begin
        hsync    <= 1'b1;
        vsync    <= 1'b1;
        video_on <= 1'b0;
      end else begin
        hsync    <= !((h_nx >= HS_FIRST) && (h_nx <= HS_LAST));
        vsync    <= !((v_nx >= VS_FIRST) && (v_nx <= VS_LAST));
        video_on <= (h_nx < H_VIS_L) && (v_nx < V_VIS_L);
      end
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

`ifdef VGA_FRAME_TICK_EN
  // Pulse on the first tick out of IDLE, and on every frame wrap that stays
  // in RUN. A wrap that ends a drain goes to IDLE and does not pulse.
  logic fs_nx;
  assign fs_nx = tick & run & ((state == S_IDLE) | ((state == S_RUN) & at_end));

  always_ff @(posedge CLK_NX or negedge reset_n) begin
    if (!reset_n) frame_start <= 1'b0;
    else          frame_start <= fs_nx;
  end
`else
  assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl. One instance uses the 640x480 timing. A second
// instance uses a tiny 16x10 raster, so that frame wrap, drain and restart
// sequences fit in a short run.
module tb_vga_sync_ctrl;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       busy;
    logic       fs;
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  typedef struct {
    bit   sel;
    int   t;
    obs_t exp;
  } vec_t;

`ifdef VGA_FRAME_TICK_EN
  localparam bit FS_ON = 1'b1;
`else
  localparam bit FS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK_NX = 1'b0;
  logic reset_n;
  logic pixel_rate;
  logic run_d, run_s;
  logic [1:0] div;
  int   cyc = 0;
  int   fs_cnt = 0;

  always #5 CLK_NX = ~CLK_NX;
  always @(posedge CLK_NX) cyc <= cyc + 1;
  always @(negedge CLK_NX) if (s_frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

  // 25 MHz square wave: period 4 CLK_NX cycles, 50% duty
  initial begin
    div = 2'd0;
    pixel_rate = 1'b0;
    forever begin
      @(posedge CLK_NX);
      #1;
      div = div + 2'd1;
      pixel_rate = div[1];
    end
  end

  // ---------------- DUTs ----------------
  logic d_hsync, d_vsync, d_video_on, d_pixel_tick, d_busy, d_frame_start;
  logic [9:0] d_pixel_x, d_pixel_y;
  logic s_hsync, s_vsync, s_video_on, s_pixel_tick, s_busy, s_frame_start;
  logic [9:0] s_pixel_x, s_pixel_y;

  vga_sync_ctrl u_dut (
    .CLK_NX      (CLK_NX),
    .reset_n     (reset_n),
    .pixel_rate  (pixel_rate),
    .run         (run_d),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .video_on    (d_video_on),
    .pixel_x     (d_pixel_x),
    .pixel_y     (d_pixel_y),
    .pixel_tick  (d_pixel_tick),
    .busy        (d_busy),
    .frame_start (d_frame_start)
  );

  // 16 x 10 raster: hsync low x in [10,12], vsync low y in [6,7],
  // visible x<8, y<4
  vga_sync_ctrl #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .CLK_NX      (CLK_NX),
    .reset_n     (reset_n),
    .pixel_rate  (pixel_rate),
    .run         (run_s),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .pixel_x     (s_pixel_x),
    .pixel_y     (s_pixel_y),
    .pixel_tick  (s_pixel_tick),
    .busy        (s_busy),
    .frame_start (s_frame_start)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [25:0] exp_q[$];
  vec_t vecs[$];

  function automatic obs_t mko(input int x, input int y, input logic hs, input logic vs,
                               input logic von, input logic busy, input logic fs, input logic pt);
    obs_t o;
    o.hs = hs; o.vs = vs; o.von = von; o.busy = busy; o.fs = fs; o.pt = pt;
    o.x = 10'(x); o.y = 10'(y);
    return o;
  endfunction

  function automatic vec_t mkv(input bit sel, input int t, input int x, input int y,
                               input logic hs, input logic vs, input logic von, input logic fs);
    vec_t v;
    v.sel = sel;
    v.t   = t;
    v.exp = mko(x, y, hs, vs, von, 1'b1, fs, 1'b1);
    return v;
  endfunction

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel) begin
      o.hs = s_hsync; o.vs = s_vsync; o.von = s_video_on; o.busy = s_busy;
      o.fs = s_frame_start; o.pt = s_pixel_tick; o.x = s_pixel_x; o.y = s_pixel_y;
    end else begin
      o.hs = d_hsync; o.vs = d_vsync; o.von = d_video_on; o.busy = d_busy;
      o.fs = d_frame_start; o.pt = d_pixel_tick; o.x = d_pixel_x; o.y = d_pixel_y;
    end
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b busy=%b fs=%b pt=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b busy=%b fs=%b pt=%b",
               name, act.x, act.y, act.hs, act.vs, act.von, act.busy, act.fs, act.pt,
               exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.busy, exp.fs, exp.pt);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Wait for the next pixel_tick of the selected DUT, sampled on the falling edge.
  task automatic wait_ptick(input bit sel);
    obs_t o;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge CLK_NX);
      o = get_obs(sel);
      if (o.pt === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: no pixel_tick on dut %0d within 16 cycles", sel);
    end
  endtask

  task automatic advance(input bit sel, input int n);
    for (int i = 0; i < n; i++) wait_ptick(sel);
  endtask

  task automatic seek(input bit sel, input int x, input int y);
    obs_t o;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      wait_ptick(sel);
      o = get_obs(sel);
      if (o.x == 10'(x) && o.y == 10'(y)) found = 1'b1;
    end
    chk_int($sformatf("seek_%0d_%0d", x, y), int'(found), 1);
  endtask

  // Call just after sampling a tick. Changes run_s during the cycle in
  // which the next tick is high, then samples the result of that tick.
  task automatic set_run_on_next_tick(input logic val);
    repeat (3) @(posedge CLK_NX);
    #2;
    run_s = val;
    wait_ptick(1'b1);
  endtask

  task automatic run_table(input bit sel);
    int t_cur;
    t_cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].sel == sel) begin
        while (t_cur < vecs[i].t) begin
          wait_ptick(sel);
          t_cur++;
        end
        exp_q.push_back(vecs[i].exp);
        chk_obs($sformatf("vec%0d_t%0d", i, vecs[i].t), get_obs(sel), obs_t'(exp_q.pop_front()));
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    obs_t rst_o, idle_o, o;
    int   pt_hi, bad, hs_low, von_hi, vs_low, first_hs, c0, fs_base;

    rst_o  = mko(0, 0, 1, 1, 0, 0, 0, 0);
    idle_o = mko(0, 0, 1, 1, 0, 0, 0, 1);

    // sel, t, x, y, hs, vs, von, fs  (t = ticks since the first RUN tick)
    vecs.push_back(mkv(0,    0,   0, 0, 1, 1, 1, FS_ON));
    vecs.push_back(mkv(0,    1,   1, 0, 1, 1, 1, 0));
    vecs.push_back(mkv(0,  639, 639, 0, 1, 1, 1, 0));
    vecs.push_back(mkv(0,  640, 640, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(0,  655, 655, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(0,  656, 656, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0,  751, 751, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0,  752, 752, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(0,  799, 799, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(0,  800,   0, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(0, 1456, 656, 1, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1599, 799, 1, 1, 1, 0, 0));
    vecs.push_back(mkv(1,    0,   0, 0, 1, 1, 1, FS_ON));
    vecs.push_back(mkv(1,    9,   9, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   10,  10, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1,   12,  12, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1,   13,  13, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   15,  15, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   16,   0, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(1,   55,   7, 3, 1, 1, 1, 0));
    vecs.push_back(mkv(1,   56,   8, 3, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   64,   0, 4, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   95,  15, 5, 1, 1, 0, 0));
    vecs.push_back(mkv(1,   96,   0, 6, 1, 0, 0, 0));
    vecs.push_back(mkv(1,  106,  10, 6, 0, 0, 0, 0));
    vecs.push_back(mkv(1,  127,  15, 7, 1, 0, 0, 0));
    vecs.push_back(mkv(1,  128,   0, 8, 1, 1, 0, 0));
    vecs.push_back(mkv(1,  159,  15, 9, 1, 1, 0, 0));
    vecs.push_back(mkv(1,  160,   0, 0, 1, 1, 1, FS_ON));
    vecs.push_back(mkv(1,  170,  10, 0, 0, 1, 0, 0));

    // Reset held with pixel_rate toggling
    reset_n = 1'b0;
    run_d   = 1'b0;
    run_s   = 1'b0;
    repeat (12) begin
      @(negedge CLK_NX);
      chk_obs("reset_hold_d", get_obs(1'b0), rst_o);
      chk_obs("reset_hold_s", get_obs(1'b1), rst_o);
    end
    reset_n = 1'b1;

    // Idle after release: only pixel_tick moves, at 1 cycle in 4
    pt_hi = 0;
    bad   = 0;
    repeat (40) begin
      @(negedge CLK_NX);
      o = get_obs(1'b0);
      if (o.pt === 1'b1) pt_hi++;
      o.pt = 1'b0;
      if (o !== rst_o) bad++;
    end
    chk_int("idle_ptick_count", pt_hi, 10);
    chk_int("idle_outputs_bad", bad, 0);

    // 640x480 line timing
    wait_ptick(1'b0);
    run_d = 1'b1;
    run_table(1'b0);
    wait_ptick(1'b0);
    c0 = cyc;
    hs_low = 0;
    von_hi = 0;
    first_hs = -1;
    for (int i = 0; i < 800; i++) begin
      o = get_obs(1'b0);
      if (o.hs == 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(o.x);
      end
      if (o.von == 1'b1) von_hi++;
      wait_ptick(1'b0);
    end
    chk_int("line_hsync_low_ticks", hs_low, 96);
    chk_int("line_hsync_first_x", first_hs, 656);
    chk_int("line_video_on_ticks", von_hi, 640);
    chk_int("line_period_cycles", cyc - c0, 3200);
    chk_obs("line_wrap", get_obs(1'b0), mko(0, 3, 1, 1, 1, 1, 0, 1));

    // Asynchronous reset in the middle of a frame
    run_d = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_obs("async_reset_d", get_obs(1'b0), rst_o);
    repeat (4) begin
      @(negedge CLK_NX);
      chk_obs("reset_mid_d", get_obs(1'b0), rst_o);
    end
    reset_n = 1'b1;

    // Small raster: frame timing through one wrap
    wait_ptick(1'b1);
    run_s = 1'b1;
    run_table(1'b1);
    vs_low = 0;
    for (int i = 0; i < 160; i++) begin
      if (get_obs(1'b1).vs == 1'b0) vs_low++;
      wait_ptick(1'b1);
    end
    chk_int("frame_vsync_low_ticks", vs_low, 32);
    chk_obs("frame_scan_end", get_obs(1'b1), mko(10, 0, 0, 1, 0, 1, 0, 1));

    // Stop request mid-frame drains to the end of the frame
    seek(1'b1, 5, 3);
    run_s = 1'b0;
    bad = 0;
    for (int i = 0; i < 106; i++) begin
      wait_ptick(1'b1);
      if (get_obs(1'b1).busy !== 1'b1) bad++;
    end
    chk_int("drain_busy_drop", bad, 0);
    chk_obs("drain_last_pixel", get_obs(1'b1), mko(15, 9, 1, 1, 0, 1, 0, 1));
    wait_ptick(1'b1);
    chk_obs("drain_to_idle", get_obs(1'b1), idle_o);
    advance(1'b1, 3);
    chk_obs("idle_stays", get_obs(1'b1), idle_o);

    // Re-run during DRAIN continues without a break
    run_s = 1'b1;
    wait_ptick(1'b1);
    chk_obs("restart_origin", get_obs(1'b1), mko(0, 0, 1, 1, 1, 1, FS_ON, 1));
    advance(1'b1, 35);
    chk_obs("rerun_drop_pos", get_obs(1'b1), mko(3, 2, 1, 1, 1, 1, 0, 1));
    run_s = 1'b0;
    advance(1'b1, 3);
    chk_obs("rerun_in_drain", get_obs(1'b1), mko(6, 2, 1, 1, 1, 1, 0, 1));
    run_s = 1'b1;
    advance(1'b1, 121);
    chk_obs("rerun_last_pixel", get_obs(1'b1), mko(15, 9, 1, 1, 0, 1, 0, 1));
    wait_ptick(1'b1);
    chk_obs("rerun_wraps_running", get_obs(1'b1), mko(0, 0, 1, 1, 1, 1, FS_ON, 1));

    // Run rise on the drain-completion tick is ignored until the next tick
    run_s = 1'b0;
    advance(1'b1, 159);
    chk_obs("drain2_last_pixel", get_obs(1'b1), mko(15, 9, 1, 1, 0, 1, 0, 1));
    set_run_on_next_tick(1'b1);
    chk_obs("drain2_idle_wins", get_obs(1'b1), idle_o);
    wait_ptick(1'b1);
    chk_obs("drain2_restart", get_obs(1'b1), mko(0, 0, 1, 1, 1, 1, FS_ON, 1));

    // Run fall on the final-pixel tick while running goes straight to IDLE
    advance(1'b1, 159);
    chk_obs("run_last_pixel", get_obs(1'b1), mko(15, 9, 1, 1, 0, 1, 0, 1));
    set_run_on_next_tick(1'b0);
    chk_obs("run_fall_final_idle", get_obs(1'b1), idle_o);
    wait_ptick(1'b1);
    chk_obs("run_fall_stays_idle", get_obs(1'b1), idle_o);

    // Reset mid-frame on the small raster, then restart with run held high
    run_s = 1'b1;
    wait_ptick(1'b1);
    advance(1'b1, 85);
    chk_obs("pre_reset_pos", get_obs(1'b1), mko(5, 5, 1, 1, 0, 1, 0, 1));
    #2;
    reset_n = 1'b0;
    #1;
    chk_obs("async_reset_s", get_obs(1'b1), rst_o);
    chk_obs("async_reset_d_idle", get_obs(1'b0), rst_o);
    repeat (3) begin
      @(negedge CLK_NX);
      chk_obs("reset_hold2_s", get_obs(1'b1), rst_o);
    end
    fs_base = fs_cnt;
    reset_n = 1'b1;
    wait_ptick(1'b1);
    chk_obs("post_reset_origin", get_obs(1'b1), mko(0, 0, 1, 1, 1, 1, FS_ON, 1));
    advance(1'b1, 160);
    chk_obs("post_reset_frame2", get_obs(1'b1), mko(0, 0, 1, 1, 1, 1, FS_ON, 1));
    @(negedge CLK_NX);
    chk_int("frame_start_pulse_cycles", fs_cnt - fs_base, 2 * int'(FS_ON));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
